// File: rtl/calc_pkg.sv
// Shared constants for the calculator front end: switch count, key code width
// and the default debounce timing used by the RTL and controller-side benches.
package calc_pkg;

    localparam int N_SW           = 14;
    localparam int KEY_CODE_W     = 4;
    localparam int TICK_DIV_DEF   = 50000;
    localparam int STABLE_CNT_DEF = 8;

    // Counter width able to hold 0..stable.
    function automatic int cnt_width(input int stable);
        return (stable < 1) ? 1 : $clog2(stable + 1);
    endfunction

endpackage

// File: rtl/psw_debounce_cell.sv
// One push switch: two-flop synchroniser, tick-driven mismatch counter,
// debounced level and registered press pulse.
module psw_debounce_cell
    import calc_pkg::*;
#(
    parameter int STABLE_CNT = STABLE_CNT_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_psw,
    input  logic i_tick,
    output logic o_lvl,
    output logic o_push,
    output logic o_push_next
);

    localparam int              CW     = cnt_width(STABLE_CNT);
    localparam logic [CW-1:0]   C_LAST = CW'(STABLE_CNT - 1);

    logic          r_s1;
    logic          r_s2;
    logic [CW-1:0] r_cnt;
    logic          r_lvl;
    logic          r_push;

    logic w_mismatch;
    logic w_accept;

    assign w_mismatch  = r_s2 ^ r_lvl;
    assign w_accept    = w_mismatch & i_tick & (r_cnt == C_LAST);
    // Only a 0->1 acceptance is a press; releases stay silent.
    assign o_push_next = w_accept & ~r_lvl;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_cnt  <= '0;
            r_lvl  <= 1'b0;
            r_push <= 1'b0;
        end else begin
            r_s1   <= i_psw;
            r_s2   <= r_s1;
            r_push <= o_push_next;
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (i_tick) begin
                if (r_cnt == C_LAST) begin
                    r_cnt <= '0;
                    r_lvl <= ~r_lvl;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_lvl  = r_lvl;
    assign o_push = r_push;

endmodule

// File: rtl/psw_debounce.sv
// Push-switch conditioning: shared sample-tick prescaler, one debounce cell per
// switch, and a lowest-index key encoder registered alongside the press pulses.
module psw_debounce
    import calc_pkg::*;
#(
    parameter int N_SW       = calc_pkg::N_SW,
    parameter int TICK_DIV   = TICK_DIV_DEF,
    parameter int STABLE_CNT = STABLE_CNT_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_SW-1:0]       i_psw,
    output logic [N_SW-1:0]       o_psw_lvl,
    output logic [N_SW-1:0]       o_psw_push,
    output logic                  o_key_valid,
    output logic [KEY_CODE_W-1:0] o_key_code
);

    localparam int            PW     = $clog2(TICK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]         r_pre;
    logic                  r_key_valid;
    logic [KEY_CODE_W-1:0] r_key_code;

    logic                  w_tick;
    logic [N_SW-1:0]       w_push_next;
    logic                  w_any;
    logic [KEY_CODE_W-1:0] w_code;

    assign w_tick = (r_pre == P_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    for (genvar g = 0; g < N_SW; g++) begin : g_cell
        psw_debounce_cell #(
            .STABLE_CNT (STABLE_CNT)
        ) u_cell (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_psw       (i_psw[g]),
            .i_tick      (w_tick),
            .o_lvl       (o_psw_lvl[g]),
            .o_push      (o_psw_push[g]),
            .o_push_next (w_push_next[g])
        );
    end

    // Scan downward so the lowest pressed index is the last one written.
    always_comb begin
        w_code = '0;
        for (int i = N_SW - 1; i >= 0; i--) begin
            if (w_push_next[i]) begin
                w_code = KEY_CODE_W'(i);
            end
        end
    end

    assign w_any = |w_push_next;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
        end else begin
            r_key_valid <= w_any;
            if (w_any) begin
                r_key_code <= w_code;
            end
        end
    end

    assign o_key_valid = r_key_valid;
    assign o_key_code  = r_key_code;

endmodule

// File: tb/tb_psw_debounce.sv
// Directed bench for psw_debounce with a short tick (TICK_DIV=4, STABLE_CNT=3).
module tb_psw_debounce;

    localparam int NSW = 14;

    logic            clk;
    logic            rst;
    logic [NSW-1:0]  psw;
    logic [NSW-1:0]  lvl;
    logic [NSW-1:0]  push;
    logic            kv;
    logic [3:0]      kc;

    int n_checks = 0;
    int n_errors = 0;

    psw_debounce #(
        .N_SW       (NSW),
        .TICK_DIV   (4),
        .STABLE_CNT (3)
    ) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_psw       (psw),
        .o_psw_lvl   (lvl),
        .o_psw_push  (push),
        .o_key_valid (kv),
        .o_key_code  (kc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns the negedge index (1-based) at which push[idx] is first seen, or -1.
    task automatic wait_push(input int idx, input int max_cyc, output int lat);
        lat = -1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (push[idx]) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int first_tick;
        int bad;
        int pulses;

        rst = 1'b1;
        psw = '0;
        repeat (3) @(negedge clk);
        check("reset_lvl",  32'(lvl),  32'h0);
        check("reset_push", 32'(push), 32'h0);
        check("reset_kv",   32'(kv),   32'h0);
        check("reset_kc",   32'(kc),   32'h0);

        // Idle after reset release: outputs stay 0, first tick in cycle 4.
        rst = 1'b0;
        first_tick = 0;
        bad = 0;
        for (int c = 1; c <= 100; c++) begin
            #1;
            if (u_dut.w_tick && first_tick == 0) first_tick = c;
            if (lvl != 0 || push != 0 || kv != 1'b0 || kc != 4'd0) bad = 1;
            @(negedge clk);
        end
        check("first_tick_cycle", 32'(first_tick), 32'd4);
        check("idle_outputs_quiet", 32'(bad), 32'd0);

        // Single press on switch 5.
        psw[5] = 1'b1;
        wait_push(5, 20, lat);
        check("p5_latency_11_14", 32'(lat >= 11 && lat <= 14), 32'd1);
        check("p5_push_vec", 32'(push), 32'h020);
        check("p5_lvl",      32'(lvl),  32'h020);
        check("p5_kv",       32'(kv),   32'd1);
        check("p5_kc",       32'(kc),   32'd5);
        @(negedge clk);
        check("p5_push_width", 32'(push), 32'h0);
        check("p5_kv_width",   32'(kv),   32'd0);
        check("p5_kc_hold",    32'(kc),   32'd5);
        check("p5_lvl_hold",   32'(lvl),  32'h020);

        // Switch 2 bouncing every 5 cycles: never accepted.
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            psw[2] = (((c / 5) % 2) == 0);
            @(negedge clk);
            if (push[2] || lvl[2] || kv) bad = 1;
        end
        check("bounce_rejected", 32'(bad), 32'd0);
        psw[2] = 1'b1;
        wait_push(2, 20, lat);
        check("p2_latency_le_14", 32'(lat >= 11 && lat <= 14), 32'd1);
        check("p2_kc", 32'(kc), 32'd2);
        check("p2_lvl", 32'(lvl), 32'h024);

        // Switches 3 and 9 together.
        @(negedge clk);
        psw[3] = 1'b1;
        psw[9] = 1'b1;
        wait_push(3, 20, lat);
        check("p39_latency", 32'(lat >= 11 && lat <= 14), 32'd1);
        check("p39_push_vec", 32'(push), 32'h208);
        check("p39_kv", 32'(kv), 32'd1);
        check("p39_kc", 32'(kc), 32'd3);
        @(negedge clk);
        check("p39_push_clear", 32'(push), 32'h0);
        check("p39_kc_hold", 32'(kc), 32'd3);
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            if (kv) pulses++;
            @(negedge clk);
        end
        check("p39_no_extra_kv", 32'(pulses), 32'd0);

        // Press and then release switch 0.
        psw[0] = 1'b1;
        wait_push(0, 20, lat);
        check("p0_latency", 32'(lat >= 11 && lat <= 14), 32'd1);
        check("p0_kc_lowest", 32'(kc), 32'd0);
        check("p0_lvl", 32'(lvl), 32'h22D);
        repeat (5) @(negedge clk);
        psw[0] = 1'b0;
        lat = -1;
        bad = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (push != 0 || kv) bad = 1;
            if (!lvl[0]) begin
                lat = c;
                break;
            end
        end
        check("r0_latency", 32'(lat >= 11 && lat <= 14), 32'd1);
        check("r0_silent", 32'(bad), 32'd0);
        check("r0_lvl", 32'(lvl), 32'h22C);
        check("r0_kc_hold", 32'(kc), 32'd0);

        // Press switch 7, then pulse reset while it is held.
        psw[7] = 1'b1;
        wait_push(7, 20, lat);
        check("p7_latency", 32'(lat >= 11 && lat <= 14), 32'd1);
        check("p7_kc", 32'(kc), 32'd7);
        check("p7_lvl", 32'(lvl), 32'h2AC);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_lvl",  32'(lvl),  32'h0);
        check("async_rst_push", 32'(push), 32'h0);
        check("async_rst_kv",   32'(kv),   32'd0);
        check("async_rst_kc",   32'(kc),   32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // All held switches re-debounce together from a freshly reset prescaler.
        wait_push(7, 20, lat);
        check("rerun_latency", 32'(lat), 32'd12);
        check("rerun_push_vec", 32'(push), 32'h2AC);
        check("rerun_kv", 32'(kv), 32'd1);
        check("rerun_kc", 32'(kc), 32'd2);
        @(negedge clk);
        check("rerun_push_clear", 32'(push), 32'h0);
        check("rerun_lvl", 32'(lvl), 32'h2AC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/psw_debounce.md
# psw_debounce

Input-conditioning stage for the calculator top level. It takes the raw 14-bit push-switch bus from the board and synchronises and debounces each switch. It produces clean level and single-cycle press pulses plus an encoded key event, so the calculator controller consumes glitch-free key strokes instead of raw switch levels. It sits between the board pins and the controller's PSW input.

## Interface
Parameters:
- N_SW, 14, number of push switches.
- TICK_DIV, 50000, sample-tick prescaler period in CLK cycles (1 ms at 50 MHz); must be ≥ 2.
- STABLE_CNT, 8, consecutive mismatching ticks required to accept a new level; must be ≥ 1.

Ports:
- CLK  input  1  system clock, single clock domain.
- RST  input  1  asynchronous, active-high reset.
- PSW  input  N_SW  raw switch levels, asynchronous to CLK; 1 = pressed.
- PSW_LVL  output  N_SW  debounced switch levels.
- PSW_PUSH  output  N_SW  one-cycle pulse per switch on each debounced 0→1 transition.
- KEY_VALID  output  1  one-cycle pulse when any PSW_PUSH bit is high.
- KEY_CODE  output  4  index of the lowest set PSW_PUSH bit; holds its last value while KEY_VALID is low.

## Operation
- Reset: PSW_LVL, PSW_PUSH, KEY_VALID and KEY_CODE are 0. Synchroniser flops, the prescaler and all debounce counters are also 0.
- Synchroniser: a 2-flop chain per switch. sync[i] is PSW[i] delayed by 2 cycles.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick is high for one cycle when the count equals TICK_DIV-1. The first tick occurs in cycle TICK_DIV after reset release.
- Per-switch debounce, with cnt width ceil(log2(STABLE_CNT+1)):
  - When sync[i] equals PSW_LVL[i], cnt is cleared every cycle, whether or not a tick occurs.
  - On a tick with a mismatch and cnt < STABLE_CNT-1, cnt increments.
  - On a tick with a mismatch and cnt == STABLE_CNT-1, PSW_LVL[i] toggles and cnt clears.
  - Net effect: a level is accepted only after STABLE_CNT consecutive ticks all see the mismatch. Any bounce back to the current level restarts the count.
- Press pulse: PSW_PUSH[i] is registered alongside PSW_LVL[i]. It is high exactly in the first cycle PSW_LVL[i] reads 1. Releases (1→0) produce no pulse.
- Key encoder: KEY_VALID and KEY_CODE are registered in the same cycle as PSW_PUSH, computed from the next-state push vector.
  - Simultaneous presses: KEY_CODE is the lowest index. All pressed bits still appear in PSW_PUSH.
- Switches are independent; state never crosses between switches.

## Timing
- Latency from a stable PSW edge to PSW_LVL: 2 synchroniser cycles, then a mismatch over STABLE_CNT ticks. Worst case is 2 + STABLE_CNT·TICK_DIV cycles; best case is 2 + (STABLE_CNT-1)·TICK_DIV + 1 cycles.
- PSW_PUSH, KEY_VALID and KEY_CODE change in the same cycle as PSW_LVL. Pulse width is exactly 1 cycle.
- Minimum spacing between two pulses on the same switch is 2·STABLE_CNT ticks (a press followed by an accepted release).
- Reset mid-operation clears all state immediately (asynchronous). A switch still held after release of RST re-debounces from level 0 and generates a fresh press pulse.
- Prescaler wrap and counter saturation cannot overflow: cnt never exceeds STABLE_CNT-1.

## Structure
- Shared package calc_pkg holds:
  - N_SW = 14.
  - KEY_CODE_W = 4.
  - Default TICK_DIV and STABLE_CNT constants, also used by controller-side testbenches.
- Sub-module psw_debounce_cell covers one switch: synchroniser, counter, level and push flops. It is instantiated N_SW times.
- The top holds the shared prescaler and the priority encoder.

## Test plan
Run with TICK_DIV=4 and STABLE_CNT=3.
- Reset release, PSW=0 held: all outputs 0 for 100 cycles. The first tick appears at cycle 4.
- PSW[5] rises and is held: PSW_LVL[5]=1 and a 1-cycle PSW_PUSH[5] within 11–14 cycles. KEY_VALID=1 and KEY_CODE=5 in the same cycle.
- PSW[2] toggles every 5 cycles (bounce shorter than 3 ticks) for 60 cycles: PSW_LVL[2] stays 0 with no pulse. After it settles high, a pulse follows within 14 cycles.
- PSW[3] and PSW[9] rise in the same cycle: PSW_PUSH=0x208 for one cycle, KEY_CODE=3, one KEY_VALID pulse.
- Held PSW[0] is released: PSW_LVL[0] falls after 3 ticks, with no PSW_PUSH and no KEY_VALID.
- RST pulsed while PSW[7] is held and PSW_LVL[7]=1: outputs clear asynchronously. After release, PSW_PUSH[7] pulses again within 14 cycles.
